// File: rtl/uart_rx_wb_writer.sv
// Packs UART bytes into little-endian 32-bit words, queues them in a small word FIFO,
// and writes them as a Wishbone master into a circular RAM window.
module uart_rx_wb_writer #(
    parameter int          BITS       = 8,
    parameter logic [31:0] ADR_LL     = 32'h00C0_0000,
    parameter logic [31:0] ADR_UL     = 32'h00C1_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst,
    input  logic            i_rx_valid,
    input  logic [BITS-1:0] i_rx_data,
    input  logic            i_flush,
    output logic [31:0]     o_wb_adr,
    output logic [31:0]     o_wb_dat,
    output logic [3:0]      o_wb_sel,
    output logic            o_wb_we,
    output logic            o_wb_cyc,
    input  logic            i_wb_ack,
    output logic            o_overrun,
    output logic            o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t        state_q;
    logic [31:0]   pk_dat_q, pk_dat_d;
    logic [2:0]    pk_cnt_q, pk_cnt_d;
    logic [35:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   rd_q, wr_q;
    logic [31:0]   wr_ptr_q, wr_ptr_nxt;
    logic [31:0]   adr_q, dat_q;
    logic [3:0]    sel_q;
    logic          cyc_q, overrun_q;

    logic          push, pop, accept, empty, full;
    logic [31:0]   push_dat;
    logic [3:0]    push_sel;
    logic [35:0]   head;

    // The incoming byte is packed before a same-cycle flush is evaluated.
    always_comb begin
        pk_dat_d = pk_dat_q;
        pk_cnt_d = pk_cnt_q;
        if (i_rx_valid) begin
            pk_dat_d[BITS*int'(pk_cnt_q[1:0]) +: BITS] = i_rx_data;
            pk_cnt_d = pk_cnt_q + 3'd1;
        end
        push     = (pk_cnt_d == 3'd4) || (i_flush && (pk_cnt_d != 3'd0));
        push_dat = pk_dat_d;
        case (pk_cnt_d)
            3'd1:    push_sel = 4'b0001;
            3'd2:    push_sel = 4'b0011;
            3'd3:    push_sel = 4'b0111;
            default: push_sel = 4'b1111;
        endcase
        if (push) begin
            pk_dat_d = '0;
            pk_cnt_d = '0;
        end
    end

    assign empty  = (rd_q == wr_q);
    assign full   = (rd_q[AW] != wr_q[AW]) && (rd_q[AW-1:0] == wr_q[AW-1:0]);
    assign pop    = (state_q == S_WRITE) && i_wb_ack;
    assign accept = push && (!full || pop);
    // An empty FIFO forwards the word being pushed so cyc can rise one cycle after the last byte.
    assign head   = empty ? {push_sel, push_dat} : mem_q[rd_q[AW-1:0]];

    assign wr_ptr_nxt = (wr_ptr_q + 32'd4 == ADR_UL) ? ADR_LL : wr_ptr_q + 32'd4;

    always_ff @(posedge i_wb_clk) begin
        if (accept) mem_q[wr_q[AW-1:0]] <= {push_sel, push_dat};
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q   <= S_IDLE;
            pk_dat_q  <= '0;
            pk_cnt_q  <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            wr_ptr_q  <= ADR_LL;
            adr_q     <= ADR_LL;
            dat_q     <= '0;
            sel_q     <= '0;
            cyc_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            pk_dat_q <= pk_dat_d;
            pk_cnt_q <= pk_cnt_d;
            if (accept) wr_q <= wr_q + 1'b1;
            if (push && !accept) overrun_q <= 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (!empty || push) begin
                        adr_q   <= wr_ptr_q;
                        sel_q   <= head[35:32];
                        dat_q   <= head[31:0];
                        cyc_q   <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_wb_ack) begin
                        cyc_q    <= 1'b0;
                        wr_ptr_q <= wr_ptr_nxt;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_wb_adr  = adr_q;
    assign o_wb_dat  = dat_q;
    assign o_wb_sel  = sel_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_we   = cyc_q;
    assign o_overrun = overrun_q;
    assign o_busy    = !empty || cyc_q || (pk_cnt_q != 3'd0);

endmodule

// File: tb/tb_uart_rx_wb_writer.sv
// Directed bench for uart_rx_wb_writer: a default-window instance and a 16-byte-window
// instance share all inputs so pointer wrap is observed alongside the main checks.
module tb_uart_rx_wb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        flush = 1'b0;
    logic        ack = 1'b0;

    logic [31:0] adr_a, dat_a, adr_b, dat_b;
    logic [3:0]  sel_a, sel_b;
    logic        we_a, cyc_a, ovr_a, busy_a;
    logic        we_b, cyc_b, ovr_b, busy_b;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    uart_rx_wb_writer dut_a (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_flush(flush), .o_wb_adr(adr_a), .o_wb_dat(dat_a), .o_wb_sel(sel_a),
        .o_wb_we(we_a), .o_wb_cyc(cyc_a), .i_wb_ack(ack), .o_overrun(ovr_a), .o_busy(busy_a)
    );

    uart_rx_wb_writer #(.ADR_LL(32'h0), .ADR_UL(32'd16)) dut_b (
        .i_wb_clk(clk), .i_wb_rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .i_flush(flush), .o_wb_adr(adr_b), .o_wb_dat(dat_b), .o_wb_sel(sel_b),
        .o_wb_we(we_b), .o_wb_cyc(cyc_b), .i_wb_ack(ack), .o_overrun(ovr_b), .o_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; flush = 1'b0; ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fl);
        rx_valid = 1'b1; rx_data = b; flush = fl;
        @(posedge clk);
        #1 rx_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic send_flush();
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
    endtask

    // Waits (bounded) for a write, checks it on both instances, then acks one cycle.
    task automatic wb_expect(input string tag, input logic [31:0] e_adr,
                             input logic [31:0] e_dat, input logic [3:0] e_sel);
        int n = 0;
        @(negedge clk);
        while (!cyc_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cyc"}, {31'b0, cyc_a}, 32'd1);
        chk({tag, "_we"}, {31'b0, we_a}, 32'd1);
        chk({tag, "_adr"}, adr_a, e_adr);
        chk({tag, "_dat"}, dat_a, e_dat);
        chk({tag, "_sel"}, {28'b0, sel_a}, {28'b0, e_sel});
        chk({tag, "_adr_b"}, adr_b, (e_adr - 32'h00C0_0000) % 32'd16);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        @(negedge clk);
        chk({tag, "_cyc_drop"}, {31'b0, cyc_a}, 32'd0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_cyc", {31'b0, cyc_a}, 32'd0);
        chk("rst_we", {31'b0, we_a}, 32'd0);
        chk("rst_adr", adr_a, 32'h00C0_0000);
        chk("rst_dat", dat_a, 32'd0);
        chk("rst_sel", {28'b0, sel_a}, 32'd0);
        chk("rst_ovr", {31'b0, ovr_a}, 32'd0);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_adr_b", adr_b, 32'd0);

        // Full word, cyc one cycle after the 4th byte
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        chk("t1_busy_pk", {31'b0, busy_a}, 32'd1);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("t1_latency", {31'b0, cyc_a}, 32'd1);
        wb_expect("t1", 32'h00C0_0000, 32'h4433_2211, 4'hF);
        chk("t1_idle_busy", {31'b0, busy_a}, 32'd0);

        // Partial word flush then full word at the next slot
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_flush();
        wb_expect("t2a", 32'h00C0_0000, 32'h0000_BBAA, 4'h3);
        send_word(32'h0403_0201);
        wb_expect("t2b", 32'h00C0_0004, 32'h0403_0201, 4'hF);
        send_byte(8'h5A, 1'b0);
        send_flush();
        wb_expect("t2c", 32'h00C0_0008, 32'h0000_005A, 4'h1);

        // Five words: small window wraps 0,4,8,C,0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_word(32'hA0B0_C000 + i);
            wb_expect($sformatf("t3_%0d", i), 32'h00C0_0000 + 4 * i, 32'hA0B0_C000 + i, 4'hF);
        end

        // Ack stalled: six words sent, two dropped
        do_reset();
        for (int i = 0; i < 6; i++) send_word(32'h1000_0000 * (i + 1) + i);
        @(negedge clk);
        chk("t4_ovr", {31'b0, ovr_a}, 32'd1);
        chk("t4_busy", {31'b0, busy_a}, 32'd1);
        for (int i = 0; i < 4; i++)
            wb_expect($sformatf("t4_%0d", i), 32'h00C0_0000 + 4 * i,
                      32'h1000_0000 * (i + 1) + i, 4'hF);
        repeat (6) @(negedge clk);
        chk("t4_no_5th", {31'b0, cyc_a}, 32'd0);
        chk("t4_drained", {31'b0, busy_a}, 32'd0);
        chk("t4_ovr_sticky", {31'b0, ovr_a}, 32'd1);

        // 4th byte with flush gives one write; flush on empty packer does nothing
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        wb_expect("t5", 32'h00C0_0000, 32'h0403_0201, 4'hF);
        repeat (5) @(negedge clk);
        chk("t5_single", {31'b0, cyc_a}, 32'd0);
        send_flush();
        repeat (5) @(negedge clk);
        chk("t5_empty_flush", {31'b0, cyc_a}, 32'd0);
        chk("t5_empty_busy", {31'b0, busy_a}, 32'd0);

        // Reset mid-write discards in-flight and queued words; late ack ignored
        do_reset();
        send_word(32'hDEAD_BEEF);
        send_word(32'hCAFE_F00D);
        @(negedge clk);
        chk("t6_open", {31'b0, cyc_a}, 32'd1);
        #6 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_cyc", {31'b0, cyc_a}, 32'd0);
        chk("t6_adr", adr_a, 32'h00C0_0000);
        chk("t6_busy", {31'b0, busy_a}, 32'd0);
        ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_late_cyc", {31'b0, cyc_a}, 32'd0);
        chk("t6_late_adr", adr_a, 32'h00C0_0000);
        chk("t6_late_busy", {31'b0, busy_a}, 32'd0);
        send_word(32'h7766_5544);
        wb_expect("t6_after", 32'h00C0_0000, 32'h7766_5544, 4'hF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
